// File: rtl/sort_feeder.sv
// Input FIFO feeding an odd/even sorter: buffers upstream words and issues
// them one per cycle as a registered num/enable strobe under start/stop control.
module sort_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] num,
  output logic             enable,
  output logic             busy,
  output logic [15:0]      odd_cnt,
  output logic [15:0]      even_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic [WIDTH-1:0] num_r;
  logic             enable_r;
  logic [15:0]      odd_cnt_r;
  logic [15:0]      even_cnt_r;
  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;

  // Handshake and pop qualification, all from registered state.
  always_comb begin
    in_ready_s = (count_r != FULL_CNT) && (state_r != ST_DRAIN);
    push_s     = in_valid && in_ready_s;
    pop_s      = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (count_r != '0);
    head_s     = mem_r[rd_ptr_r];
  end

  // Next-state logic; in DRAIN the pop of the last word returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_nxt_s = ST_DRAIN;
        else      state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (count_r <= (PW+1)'(1)) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FIFO storage; contents are qualified by the occupancy counter, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue register and saturating parity counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_r      <= '0;
      enable_r   <= 1'b0;
      odd_cnt_r  <= 16'd0;
      even_cnt_r <= 16'd0;
    end else begin
      enable_r <= pop_s;
      if (pop_s) begin
        num_r <= head_s;
        if (head_s[0]) begin
          if (odd_cnt_r != 16'hFFFF) odd_cnt_r <= odd_cnt_r + 16'd1;
        end else begin
          if (even_cnt_r != 16'hFFFF) even_cnt_r <= even_cnt_r + 16'd1;
        end
      end
    end
  end

  assign in_ready = in_ready_s;
  assign num      = num_r;
  assign enable   = enable_r;
  assign busy     = (state_r != ST_IDLE);
  assign odd_cnt  = odd_cnt_r;
  assign even_cnt = even_cnt_r;

endmodule

// File: tb/tb_sort_feeder.sv
// Directed bench for sort_feeder: a vector table for the basic issue flow plus
// hand-written sequences for fill/backpressure, streaming, drain and reset.
module tb_sort_feeder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] num;
  logic        enable;
  logic        busy;
  logic [15:0] odd_cnt;
  logic [15:0] even_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        valid;
    logic [31:0] data;
    logic        rdy;
    logic        en;
    logic [31:0] num;
    logic        busy;
    logic [15:0] odd;
    logic [15:0] even;
  } vec_t;

  vec_t tbl [12];

  sort_feeder #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .num(num), .enable(enable), .busy(busy),
    .odd_cnt(odd_cnt), .even_cnt(even_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready before the edge, outputs after it.
  task automatic step(input logic st, input logic sp, input logic v, input logic [31:0] d,
                      input logic rdy, input logic en, input logic [31:0] nm,
                      input logic bz, input string tag);
    start = st; stop = sp; in_valid = v; in_data = d;
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    chk({tag, "_enable"}, 32'(enable), 32'(en));
    chk({tag, "_num"}, num, nm);
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] o, input logic [15:0] e);
    chk({tag, "_odd_cnt"}, 32'(odd_cnt), 32'(o));
    chk({tag, "_even_cnt"}, 32'(even_cnt), 32'(e));
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'd3, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'd8, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 16'd0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 1'b1, 16'd1, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 1'b1, 16'd1, 16'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b1, 16'd2, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b1, 16'd2, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b1, 16'd2, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd5, 1'b0, 16'd2, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b0, 16'd2, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b0, 16'd2, 16'd1};

    reset = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    #3;
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_num", num, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_cnt("rst", 16'd0, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(in_ready), 32'd1);

    // Push 3,8,5 in IDLE, start, issue; then stop/drain and start+stop in IDLE.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].valid, tbl[i].data,
           tbl[i].rdy, tbl[i].en, tbl[i].num, tbl[i].busy, $sformatf("tbl%0d", i));
      chk_cnt($sformatf("tbl%0d", i), tbl[i].odd, tbl[i].even);
    end

    // Fill to full in IDLE with in_valid held; 5th word waits for a pop.
    step(0, 0, 1, 32'd10, 1, 0, 32'd5, 0, "fill0");
    step(0, 0, 1, 32'd11, 1, 0, 32'd5, 0, "fill1");
    step(0, 0, 1, 32'd12, 1, 0, 32'd5, 0, "fill2");
    step(0, 0, 1, 32'd13, 1, 0, 32'd5, 0, "fill3");
    step(0, 0, 1, 32'd14, 0, 0, 32'd5, 0, "full_idle");
    step(1, 0, 1, 32'd14, 0, 0, 32'd5, 1, "full_start");
    step(0, 0, 1, 32'd14, 0, 1, 32'd10, 1, "full_pop");
    step(0, 0, 1, 32'd14, 1, 1, 32'd11, 1, "pushpop");
    step(0, 0, 0, 32'd0, 1, 1, 32'd12, 1, "fdrain0");
    step(0, 0, 0, 32'd0, 1, 1, 32'd13, 1, "fdrain1");
    step(0, 0, 0, 32'd0, 1, 1, 32'd14, 1, "fdrain2");
    step(0, 0, 0, 32'd0, 1, 0, 32'd14, 1, "fdrain3");
    chk_cnt("fill", 16'd4, 16'd4);

    // Streaming 1..10 in RUN: one strobe per cycle after the first.
    for (int i = 1; i <= 10; i++)
      step(0, 0, 1, 32'(i), 1, (i > 1), (i > 1) ? 32'(i - 1) : 32'd14, 1, $sformatf("stream%0d", i));
    step(0, 0, 0, 32'd0, 1, 1, 32'd10, 1, "stream_last");
    step(0, 0, 0, 32'd0, 1, 0, 32'd10, 1, "stream_idle");
    chk_cnt("stream", 16'd9, 16'd9);

    // Back to IDLE, queue 4, start, then stop: drain with push blocked.
    step(0, 1, 0, 32'd0, 1, 0, 32'd10, 1, "s_stop");
    step(0, 0, 0, 32'd0, 0, 0, 32'd10, 0, "s_idle");
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'(20 + i), 1, 0, 32'd10, 0, $sformatf("q%0d", i));
    step(1, 0, 0, 32'd0, 0, 0, 32'd10, 1, "d_start");
    step(0, 1, 0, 32'd0, 0, 1, 32'd20, 1, "d_stop");
    step(0, 0, 1, 32'd99, 0, 1, 32'd21, 1, "drain1");
    step(0, 0, 1, 32'd99, 0, 1, 32'd22, 1, "drain2");
    step(0, 0, 1, 32'd99, 0, 1, 32'd23, 0, "drain_last");
    step(0, 0, 0, 32'd0, 1, 0, 32'd23, 0, "drain_done");
    step(1, 0, 0, 32'd0, 1, 0, 32'd23, 1, "nostale_start");
    step(0, 0, 0, 32'd0, 1, 0, 32'd23, 1, "nostale");
    chk_cnt("drain", 16'd11, 16'd11);
    step(0, 1, 0, 32'd0, 1, 0, 32'd23, 1, "r_stop");
    step(0, 0, 0, 32'd0, 0, 0, 32'd23, 0, "r_idle");

    // Reset with two words still queued in RUN.
    step(0, 0, 1, 32'd30, 1, 0, 32'd23, 0, "rq0");
    step(0, 0, 1, 32'd31, 1, 0, 32'd23, 0, "rq1");
    step(0, 0, 1, 32'd32, 1, 0, 32'd23, 0, "rq2");
    step(1, 0, 0, 32'd0, 1, 0, 32'd23, 1, "rq_start");
    step(0, 0, 0, 32'd0, 1, 1, 32'd30, 1, "rq_pop");
    reset = 1'b0;
    #1;
    chk("mid_rst_enable", 32'(enable), 32'd0);
    chk("mid_rst_num", num, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk_cnt("mid_rst", 16'd0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    step(0, 0, 0, 32'd0, 1, 0, 32'd0, 0, "post_rst_idle");
    step(1, 0, 0, 32'd0, 1, 0, 32'd0, 1, "post_rst_start");
    step(0, 0, 0, 32'd0, 1, 0, 32'd0, 1, "post_rst0");
    step(0, 0, 0, 32'd0, 1, 0, 32'd0, 1, "post_rst1");
    chk_cnt("post_rst", 16'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
